// File: rtl/data_mem_ctrl_if.sv
// Load/store bus between a requester and data_mem_ctrl.
// InjErr exists only when DATA_MEM_PARITY_EN is defined.
interface data_mem_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              Req;
   logic              Write;
   logic [ADDR_W-1:0] Addr;
   logic [DATA_W-1:0] WData;
`ifdef DATA_MEM_PARITY_EN
   logic              InjErr;
`endif
   logic              Ready;
   logic              Ack;
   logic              Err;
   logic [DATA_W-1:0] RData;

`ifdef DATA_MEM_PARITY_EN
   modport master (output Req, Write, Addr, WData, InjErr,
                   input  Ready, Ack, Err, RData);
   modport slave  (input  Req, Write, Addr, WData, InjErr,
                   output Ready, Ack, Err, RData);
`else
   modport master (output Req, Write, Addr, WData,
                   input  Ready, Ack, Err, RData);
   modport slave  (input  Req, Write, Addr, WData,
                   output Ready, Ack, Err, RData);
`endif
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with req/ack handshake, WAIT extra access cycles and
// address range checking. Optional per-word even parity: DATA_MEM_PARITY_EN.
module data_mem_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   parameter int WAIT   = 0
) (
   input logic            Clock,
   input logic            Resetn,
   data_mem_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_C = 4'(WAIT);
`ifdef DATA_MEM_PARITY_EN
   localparam int         MEM_W  = DATA_W + 1;
`else
   localparam int         MEM_W  = DATA_W;
`endif

   logic [MEM_W-1:0]  mem_q [DEPTH];

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
`ifdef DATA_MEM_PARITY_EN
   logic              inj_q;
`endif

   logic              accept;
   logic              in_range;
   logic              mem_we;
   logic              par_bad;
   logic [IDX_W-1:0]  idx;
   logic [MEM_W-1:0]  rd_word;
   logic [MEM_W-1:0]  wr_word;

   assign accept   = (state_q == S_IDLE) && bus.Req;
   assign in_range = ({{(32-ADDR_W){1'b0}}, addr_q} < 32'(DEPTH));
   assign idx      = addr_q[IDX_W-1:0];
   assign rd_word  = mem_q[idx];

`ifdef DATA_MEM_PARITY_EN
   // Stored word is {parity, data}; a healthy word XORs to zero overall.
   assign wr_word = {(^wdata_q) ^ inj_q, wdata_q};
   assign par_bad = ^rd_word;
`else
   assign wr_word = wdata_q;
   assign par_bad = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.Req) begin
               state_d = S_ACCESS;
               cnt_d   = WAIT_C;
               err_d   = 1'b0;
            end
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               mem_we  = wr_q && in_range;
               err_d   = !in_range || (!wr_q && par_bad);
               if (!wr_q) begin
                  rdata_d = in_range ? rd_word[DATA_W-1:0] : '0;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Request fields are captured once at acceptance and held for the access.
   always_ff @(posedge Clock) begin
      if (accept) begin
         wr_q    <= bus.Write;
         addr_q  <= bus.Addr;
         wdata_q <= bus.WData;
`ifdef DATA_MEM_PARITY_EN
         inj_q   <= bus.InjErr;
`endif
      end
   end

   always_ff @(posedge Clock) begin
      if (mem_we) begin
         mem_q[idx] <= wr_word;
      end
   end

   assign bus.Ready = (state_q == S_IDLE);
   assign bus.Ack   = (state_q == S_RESP);
   assign bus.Err   = (state_q == S_RESP) && err_q;
   assign bus.RData = rdata_q;

endmodule
